// File: rtl/ram_pkg.sv
// Shared command codes and default geometry for the 8x4 dual-port RAM and its FIFO controller.
package ram_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RW   = 2'd3;

    localparam int DATA_WIDTH_DEF = 4;
    localparam int ADDR_WIDTH_DEF = 3;

    function automatic logic [1:0] cmd_code(input logic wr, input logic rd);
        logic [1:0] code;
        case ({wr, rd})
            2'b10:   code = ST_WR;
            2'b01:   code = ST_RD;
            2'b11:   code = ST_RW;
            default: code = ST_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Write/read pointers and occupancy count for the RAM FIFO; status flags decode from the count.
module fifo_ptr
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int ALMOST_FULL  = 6,
    parameter int ALMOST_EMPTY = 1
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  wr_ok,
    input  logic                  rd_ok,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(ALMOST_FULL);
    localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(ALMOST_EMPTY);

    logic [ADDR_WIDTH:0] count;

    // Pointers wrap naturally mod DEPTH; a simultaneous read and write leaves count unchanged.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO front-end that issues RAM command cycles and captures read data two cycles after a pop.
// Optional FIFO_ERR_CNT_EN adds saturating 8-bit counters of rejected pushes and pops.
module ram_fifo_ctrl
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int ALMOST_FULL  = 6,
    parameter int ALMOST_EMPTY = 1
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  enable,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_out_c,
    output logic [1:0]            state,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0] data_pop,
    output logic                  valid_pop,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
`ifdef FIFO_ERR_CNT_EN
    ,
    output logic [7:0]            ovf_cnt,
    output logic [7:0]            udf_cnt
`endif
);

    logic                  wr_ok, rd_ok, ovf_ev, udf_ev;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                  rd_vld_p0, rd_vld_p1;

    // A push into a full FIFO is still taken when a pop frees the slot in the same cycle.
    assign wr_ok  = enable & push & (~fifo_full | pop);
    assign rd_ok  = enable & pop & ~fifo_empty;
    assign ovf_ev = enable & push & fifo_full & ~pop;
    assign udf_ev = enable & pop & fifo_empty;

    fifo_ptr #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .ALMOST_FULL  (ALMOST_FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY)
    ) u_ptr (
        .clk          (clk),
        .reset_L      (reset_L),
        .wr_ok        (wr_ok),
        .rd_ok        (rd_ok),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    // Stage p0: registered RAM command; address/data hold when no operation is accepted.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state    <= ST_IDLE;
            data_in  <= '0;
            addr_in  <= '0;
            addr_out <= '0;
        end else begin
            state <= cmd_code(wr_ok, rd_ok);
            if (wr_ok) begin
                data_in <= data_push;
                addr_in <= wr_ptr;
            end
            if (rd_ok) addr_out <= rd_ptr;
        end
    end

    // Stages p0..p2: read tracking runs regardless of enable so an issued read always returns.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rd_vld_p0 <= 1'b0;
            rd_vld_p1 <= 1'b0;
            valid_pop <= 1'b0;
            data_pop  <= '0;
        end else begin
            rd_vld_p0 <= rd_ok;
            rd_vld_p1 <= rd_vld_p0;
            valid_pop <= rd_vld_p1;
            if (rd_vld_p1) data_pop <= data_out_c;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_ev) overflow  <= 1'b1;
            if (udf_ev) underflow <= 1'b1;
        end
    end

`ifdef FIFO_ERR_CNT_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ovf_cnt <= '0;
            udf_cnt <= '0;
        end else begin
            if (ovf_ev) ovf_cnt <= sat_inc8(ovf_cnt);
            if (udf_ev) udf_cnt <= sat_inc8(udf_cnt);
        end
    end
`endif

endmodule
